encoder_12to4: RTL and testbench

//   Registered 12-to-4 binary encoder for keypad/launchpad button lines.

---
 rtl/encoder_12to4.sv | 78 +++++++
 tb/tb_encoder_12to4.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/encoder_12to4.sv
// Registered 12-to-4 priority encoder with a full one-hot check on chk.
// Optional macro ENCODER_HOLD_EN: with no input high, out_binary holds its last value.
module encoder_12to4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_0,
    input  logic       in_1,
    input  logic       in_2,
    input  logic       in_3,
    input  logic       in_4,
    input  logic       in_5,
    input  logic       in_6,
    input  logic       in_7,
    input  logic       in_8,
    input  logic       in_9,
    input  logic       in_10,
    input  logic       in_11,
    output logic [3:0] out_binary,
    output logic       chk
);

    logic [11:0] w_in;
    logic [3:0]  w_count;
    logic [3:0]  w_hi_idx;
    logic        w_any;
    logic        w_one_hot;
    logic [3:0]  w_next_out;

    logic [3:0]  r_out_binary;
    logic        r_chk;

    assign w_in = {in_11, in_10, in_9, in_8, in_7, in_6,
                   in_5,  in_4,  in_3, in_2, in_1, in_0};

    // True popcount over all twelve lines; max value 12 fits in 4 bits.
    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < 12; i++) begin
            w_count = w_count + {3'b000, w_in[i]};
        end
    end

    assign w_one_hot = (w_count == 4'd1);

    // Ascending scan: the last asserted line seen is the highest index.
    always_comb begin
        w_hi_idx = 4'd0;
        w_any    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (w_in[i]) begin
                w_hi_idx = 4'(i);
                w_any    = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef ENCODER_HOLD_EN
        w_next_out = w_any ? w_hi_idx : r_out_binary;
`else
        w_next_out = w_any ? w_hi_idx : 4'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_binary <= 4'd0;
            r_chk        <= 1'b0;
        end else begin
            r_out_binary <= w_next_out;
            r_chk        <= w_one_hot;
        end
    end

    assign out_binary = r_out_binary;
    assign chk        = r_chk;

endmodule

// File: tb/tb_encoder_12to4.sv
// Scoreboard bench for encoder_12to4: directed scenarios then random vectors.
module tb_encoder_12to4;

    logic        clk;
    logic        rst;
    logic [11:0] v_in;
    logic [3:0]  out_binary;
    logic        chk;

    int checks;
    int errors;

    // Entry: {exp_chk, exp_out_binary}; one pushed per driven edge.
    logic [4:0] exp_q[$];
    logic [3:0] m_last;

    encoder_12to4 dut (
        .clk        (clk),
        .rst        (rst),
        .in_0       (v_in[0]),
        .in_1       (v_in[1]),
        .in_2       (v_in[2]),
        .in_3       (v_in[3]),
        .in_4       (v_in[4]),
        .in_5       (v_in[5]),
        .in_6       (v_in[6]),
        .in_7       (v_in[7]),
        .in_8       (v_in[8]),
        .in_9       (v_in[9]),
        .in_10      (v_in[10]),
        .in_11      (v_in[11]),
        .out_binary (out_binary),
        .chk        (chk)
    );

    // Clock and reset defaults
    initial begin
        clk  = 1'b0;
        rst  = 1'b1;
        v_in = '0;
    end
    always #5 clk = ~clk;

    // Reference: count the raised lines, pick the highest raised index.
    function automatic logic [4:0] model(input logic [11:0] v, input logic r);
        int         n;
        int         hi;
        logic [3:0] o;
        if (r) begin
            m_last = 4'd0;
            return 5'd0;
        end
        n  = $countones(v);
        hi = -1;
        for (int k = 11; k >= 0; k--) begin
            if (hi < 0 && v[k]) hi = k;
        end
        if (n == 0) begin
`ifdef ENCODER_HOLD_EN
            o = m_last;
`else
            o = 4'd0;
`endif
        end else begin
            o = 4'(hi);
        end
        m_last = o;
        return {(n == 1), o};
    endfunction

    task automatic step(input logic [11:0] v, input logic r);
        @(negedge clk);
        v_in = v;
        rst  = r;
        exp_q.push_back(model(v, r));
    endtask

    task automatic hold(input logic [11:0] v, input logic r, input int n);
        for (int c = 0; c < n; c++) step(v, r);
    endtask

    // Monitor: every edge with a pending expectation is checked.
    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_binary !== e[3:0]) begin
                errors++;
                $display("FAIL out_binary: got %0d expected %0d at %0t", out_binary, e[3:0], $time);
            end
            checks++;
            if (chk !== e[4]) begin
                errors++;
                $display("FAIL chk: got %b expected %b at %0t", chk, e[4], $time);
            end
        end
    end

    initial begin
        logic [11:0] v;
        int          sel;
        int          wait_cnt;
        checks = 0;
        errors = 0;
        m_last = 4'd0;

        // Reset with in_5 held, then release
        hold(12'h020, 1'b1, 2);
        hold(12'h020, 1'b0, 2);

        // Single-line sweep
        for (int k = 0; k < 12; k++) begin
            v = '0;
            v[k] = 1'b1;
            hold(v, 1'b0, 3);
        end

        // All low after in_9
        hold(12'h200, 1'b0, 3);
        hold(12'h000, 1'b0, 3);

        // Two lines, then drop the higher
        hold(12'h404, 1'b0, 3);
        hold(12'h004, 1'b0, 3);

        // All high, then reset mid-press
        hold(12'hFFF, 1'b0, 3);
        hold(12'hFFF, 1'b1, 2);
        hold(12'hFFF, 1'b0, 2);

        // One-cycle pulse on in_7
        hold(12'h000, 1'b0, 2);
        step(12'h080, 1'b0);
        hold(12'h000, 1'b0, 3);

        // Randomized mix of idle, single, multi-hot and occasional reset
        for (int t = 0; t < 400; t++) begin
            sel = $urandom_range(0, 9);
            v   = '0;
            if (sel == 0) begin
                v = '0;
            end else if (sel <= 5) begin
                v[$urandom_range(0, 11)] = 1'b1;
            end else begin
                v = 12'($urandom);
            end
            step(v, (sel == 9) && ($urandom_range(0, 3) == 0));
        end

        // Drain with a bounded wait
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
